ad9648_capture_ctrl: RTL and testbench
======================================

// Module: ad9648_capture_ctrl
// PURPOSE
//   Sequences sample capture from the AD9648 dual 14-bit ADC datapath into an AXI4-Stream master.
//   Capture starts on an arm command from the AXI4-Lite register block, immediately or on an external trigger edge.
//   Streams exactly N channel-pair samples, marks the last one with TLAST, then reports done.
//   Sits between the ADC input capture logic and the DMA/stream fabric; status feeds back to the register block.
// PARAMETERS
//   CNT_W      16   width of sample-count config and counter; max capture 2^CNT_W-1 samples
//   ADC_W      14   ADC channel sample width (ADC_W <= 16)
// PORTS
//   ACLK              in   1        system clock; all ports synchronous to it
//   ARESET            in   1        asynchronous, active-high reset
//   cfg_arm           in   1        1-cycle pulse: start a capture (ignored unless IDLE or DONE)
//   cfg_abort         in   1        1-cycle pulse: abandon capture, return to IDLE
//   cfg_trig_mode     in   1        0 = start immediately, 1 = wait for ext_trig rising edge
//   cfg_num_samples   in   CNT_W    samples per capture; sampled on cfg_arm; 0 = arm is ignored
//   ext_trig          in   1        external trigger level, already synchronised to ACLK
//   adc_valid         in   1        ADC pair valid strobe (no backpressure possible)
//   adc_data_a        in   ADC_W    channel A sample
//   adc_data_b        in   ADC_W    channel B sample
//   m_axis_tdata      out  32       {b zero-extended to 16, a zero-extended to 16}
//   m_axis_tvalid     out  1        stream valid
//   m_axis_tready     in   1        stream ready
//   m_axis_tlast      out  1        high on the Nth sample of a capture
//   sts_busy          out  1        high in ARMED or CAPTURE
//   sts_done          out  1        sticky; set when Nth beat handshakes; cleared by cfg_arm/abort
//   sts_overflow      out  1        sticky; sample dropped due to stall; cleared by cfg_arm/abort
//   sts_count         out  CNT_W   samples handshaked on stream in current/last capture
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; trigger edge register 0; counters 0.
//   - FSM states: IDLE, ARMED, CAPTURE, DONE.
//     IDLE/DONE --cfg_arm & num!=0--> ARMED (trig_mode=1) or CAPTURE (trig_mode=0); latch num, clear sts_*.
//     ARMED --ext_trig & !ext_trig_q--> CAPTURE on the next cycle (edge via one register).
//     CAPTURE --Nth beat handshake--> DONE.  any state --cfg_abort--> IDLE (abort wins over arm/trigger).
//   - Acceptance: in CAPTURE, adc_valid loads the one-entry output register when it is empty or
//     handshaking this cycle; adc_valid in the cycle that enters CAPTURE is not accepted.
//   - Latency: accepted sample appears on m_axis_tdata/tvalid the cycle after adc_valid.
//   - Accept counter counts loaded samples; no load after N loaded; tlast set on Nth loaded beat.
//   - Stall: adc_valid while register full and !m_axis_tready -> sample dropped, not counted, sts_overflow set.
//   - tvalid stays high and tdata stable until handshake (AXI4-Stream rules); never drops without tready.
//   - sts_count increments per handshake; wraps never (bounded by num<=2^CNT_W-1).
//   - Abort mid-capture: output register cleared, tvalid drops next cycle even if unaccepted (no tlast sent).
//   - ARESET mid-capture: immediate return to reset values, asynchronously.
//   - adc_valid outside CAPTURE: ignored, no overflow.
// CONFIGURATION
//   AD9648_CAP_TESTPAT_EN defined: capture data replaced by internal ramp: a = counter[ADC_W-1:0],
//     b = ~counter[ADC_W-1:0]; counter resets to 0 on each cfg_arm, increments per accepted sample.
//   Not defined: adc_data_a/b pass through; ramp logic absent.
// TESTING
//   1 mode0, num=4, adc_valid every cycle, tready=1 -> 4 beats, tlast on 4th, sts_done=1, sts_count=4.
//   2 mode1, num=2, arm then ext_trig 0->1 after 10 cycles -> no beats before edge; 2 beats after.
//   3 num=8, tready=0 for 3 cycles mid-capture, adc_valid continuous -> sts_overflow=1, 8 beats delivered in order.
//   4 abort after 3 of num=10 handshakes -> IDLE, tvalid=0 next cycle, sts_busy=0, sts_done=0.
//   5 ARESET pulse during CAPTURE -> all outputs 0 same cycle; num=0 arm -> stays IDLE.
//   6 TESTPAT_EN, num=3 -> tdata 0x3FFF_0000, 0x3FFE_0001, 0x3FFD_0002.

Source files
------------

// File: rtl/ad9648_capture_ctrl.sv
// ad9648_capture_ctrl
//   Sequences AD9648 channel-pair capture into an AXI4-Stream master.
//   A capture is armed from the register block. It starts either at once
//   or on a rising edge of ext_trig. It then streams exactly N samples,
//   marks the last one with TLAST, and raises a sticky done flag.
//   The ADC side has no backpressure. A sample that arrives while the
//   single output register is stalled is dropped and flagged as overflow.
//   Optional build macro: AD9648_CAP_TESTPAT_EN replaces the ADC data with
//   an internal ramp (a = ramp, b = ~ramp).

module ad9648_capture_ctrl #(
  parameter int CNT_W = 16,
  parameter int ADC_W = 14
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic             cfg_trig_mode,
  input  logic [CNT_W-1:0] cfg_num_samples,
  input  logic             ext_trig,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data_a,
  input  logic [ADC_W-1:0] adc_data_b,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             sts_busy,
  output logic             sts_done,
  output logic             sts_overflow,
  output logic [CNT_W-1:0] sts_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             trig_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             arm_ok, trig_edge, beat, room, want, load, drop;
  logic [ADC_W-1:0] src_a, src_b;

  // Decode the control events that the state machine and the datapath both use.
  always_comb begin
    arm_ok    = cfg_arm && (cfg_num_samples != '0) &&
                ((state == S_IDLE) || (state == S_DONE));
    trig_edge = ext_trig && !trig_q;
    beat      = m_axis_tvalid && m_axis_tready;
    room      = !m_axis_tvalid || m_axis_tready;
    want      = (state == S_CAPTURE) && adc_valid && !cfg_abort && (acc_cnt != num_q);
    load      = want && room;
    drop      = want && !room;
  end

  // Select the next state. Abort overrides both arm and trigger.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    state_nxt = state;
    if (cfg_abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (arm_ok) state_nxt = cfg_trig_mode ? S_ARMED : S_CAPTURE;
        S_ARMED:        if (trig_edge) state_nxt = S_CAPTURE;
        S_CAPTURE:      if (beat && m_axis_tlast) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // State register and the one-register trigger edge detector.
  always_ff @(posedge ACLK or posedge ARESET) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (ARESET) begin
      state  <= S_IDLE;
      trig_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      trig_q <= ext_trig;
    end
  end

`ifdef AD9648_CAP_TESTPAT_EN
  logic [ADC_W-1:0] ramp;

  // The test ramp restarts on every accepted arm and advances per accepted sample.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                     ramp <= '0;
    else if (arm_ok && !cfg_abort)  ramp <= '0;
    else if (load)                  ramp <= ramp + ADC_W'(1);
  end

  assign src_a = ramp;
  assign src_b = ~ramp;
`else
  assign src_a = adc_data_a;
  assign src_b = adc_data_b;
`endif

  // Output register, the accept and handshake counters, and the sticky status flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      num_q         <= '0;
      acc_cnt       <= '0;
      sts_count     <= '0;
      sts_done      <= 1'b0;
      sts_overflow  <= 1'b0;
    end else if (cfg_abort) begin
      // A pending beat is discarded, so no TLAST is ever sent for an aborted capture.
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sts_done      <= 1'b0;
      sts_overflow  <= 1'b0;
    end else if (arm_ok) begin
      num_q         <= cfg_num_samples;
      acc_cnt       <= '0;
      sts_count     <= '0;
      sts_done      <= 1'b0;
      sts_overflow  <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tdata  <= {16'(src_b), 16'(src_a)};
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (acc_cnt + CNT_W'(1)) == num_q;
        acc_cnt       <= acc_cnt + CNT_W'(1);
      end else if (beat) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (beat)                 sts_count    <= sts_count + CNT_W'(1);
      if (beat && m_axis_tlast) sts_done     <= 1'b1;
      if (drop)                 sts_overflow <= 1'b1;
    end
  end

  assign sts_busy = (state == S_ARMED) || (state == S_CAPTURE);

endmodule

// File: tb/tb_ad9648_capture_ctrl.sv
// tb_ad9648_capture_ctrl
//   Directed bench for ad9648_capture_ctrl: a per-cycle vector table for the basic
//   capture, plus hand sequences for trigger, stall, abort and reset behaviour.
//   Define AD9648_CAP_TESTPAT_EN here and in the RTL to exercise the ramp source.

module tb_ad9648_capture_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_arm, cfg_abort, cfg_trig_mode;
  logic [15:0] cfg_num_samples;
  logic        ext_trig, adc_valid;
  logic [13:0] adc_data_a, adc_data_b;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        sts_busy, sts_done, sts_overflow;
  logic [15:0] sts_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_data[$];
  logic        beat_last[$];

  ad9648_capture_ctrl #(.CNT_W(16), .ADC_W(14)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_trig_mode(cfg_trig_mode),
    .cfg_num_samples(cfg_num_samples), .ext_trig(ext_trig),
    .adc_valid(adc_valid), .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_overflow(sts_overflow),
    .sts_count(sts_count)
  );

  always #5 ACLK = ~ACLK;

  // Record every beat that will handshake on the coming rising edge.
  always @(negedge ACLK) begin
    #2;
    if (m_axis_tvalid && m_axis_tready && !ARESET) begin
      beat_data.push_back(m_axis_tdata);
      beat_last.push_back(m_axis_tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  // Pass-through sample k drives a = k and b = k + 0x1000 (both 14 bits wide).
  task automatic drive(input int k);
    adc_data_a = 14'(k);
    adc_data_b = 14'(k + 'h1000);
  endtask

  function automatic logic [31:0] pair(input int k);
    logic [13:0] a, b;
    a = 14'(k);
    b = 14'(k + 'h1000);
    return {2'b00, b, 2'b00, a};
  endfunction

  function automatic logic [31:0] ramp_word(input int j);
    logic [13:0] a;
    a = 14'(j);
    return {2'b00, ~a, 2'b00, a};
  endfunction

  // Expected word for the j-th beat of a capture that carries ADC sample k.
  function automatic logic [31:0] exp_word(input int j, input int k);
`ifdef AD9648_CAP_TESTPAT_EN
    return ramp_word(j + 0 * k);
`else
    return pair(k + 0 * j);
`endif
  endfunction

  typedef struct {
    logic        arm;
    logic [15:0] num;
    logic        valid;
    int          k;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic arm, input logic [15:0] num, input logic valid,
                              input int k, input logic rdy, input logic e_valid,
                              input logic [31:0] e_data, input logic e_last,
                              input logic e_busy, input logic e_done, input logic [15:0] e_cnt);
    vec_t v;
    v.arm = arm; v.num = num; v.valid = valid; v.k = k; v.rdy = rdy;
    v.e_valid = e_valid; v.e_data = e_data; v.e_last = e_last;
    v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    int t;
    int exp_k[8];

    // Capture of 4 with data every cycle; an arm with num=0 is ignored; valid
    // data outside CAPTURE is ignored; a capture of 1 goes through one stall.
    vecs[0]  = mk(1, 4, 1, 0,  1, 0, 0,        0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 1, 1,  1, 1, pair(1),  0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 1, 2,  1, 1, pair(2),  0, 1, 0, 1);
    vecs[3]  = mk(0, 0, 1, 3,  1, 1, pair(3),  0, 1, 0, 2);
    vecs[4]  = mk(0, 0, 1, 4,  1, 1, pair(4),  1, 1, 0, 3);
    vecs[5]  = mk(0, 0, 1, 5,  1, 0, 0,        0, 0, 1, 4);
    vecs[6]  = mk(1, 0, 1, 6,  1, 0, 0,        0, 0, 1, 4);
    vecs[7]  = mk(0, 0, 1, 7,  1, 0, 0,        0, 0, 1, 4);
    vecs[8]  = mk(1, 1, 1, 8,  1, 0, 0,        0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 9,  1, 1, pair(9),  1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 10, 0, 1, pair(9),  1, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 11, 1, 0, 0,        0, 0, 1, 1);

    ARESET = 1'b1;
    cfg_arm = 0; cfg_abort = 0; cfg_trig_mode = 0; cfg_num_samples = 0;
    ext_trig = 0; adc_valid = 0; m_axis_tready = 0;
    drive(0);
    #12;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_ovf", sts_overflow, 0);
    check("rst_count", sts_count, 0);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Table: apply one vector per cycle and compare after the edge.
    for (int i = 0; i < 12; i++) begin
      cfg_arm = vecs[i].arm;
      cfg_num_samples = vecs[i].num;
      adc_valid = vecs[i].valid;
      m_axis_tready = vecs[i].rdy;
      drive(vecs[i].k);
      tick();
      check($sformatf("v%0d_tvalid", i), m_axis_tvalid, vecs[i].e_valid);
`ifndef AD9648_CAP_TESTPAT_EN
      if (vecs[i].e_valid) check($sformatf("v%0d_tdata", i), m_axis_tdata, vecs[i].e_data);
`endif
      check($sformatf("v%0d_tlast", i), m_axis_tlast, vecs[i].e_last);
      check($sformatf("v%0d_busy", i), sts_busy, vecs[i].e_busy);
      check($sformatf("v%0d_done", i), sts_done, vecs[i].e_done);
      check($sformatf("v%0d_ovf", i), sts_overflow, 0);
      check($sformatf("v%0d_count", i), sts_count, vecs[i].e_cnt);
    end
    cfg_arm = 0;

    // Triggered capture: no beats until the ext_trig rising edge, then exactly 2.
    beat_data.delete(); beat_last.delete();
    cfg_trig_mode = 1; cfg_num_samples = 2; adc_valid = 1; m_axis_tready = 1;
    t = 100;
    drive(t);
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    check("trig_armed_busy", sts_busy, 1);
    for (int i = 0; i < 10; i++) begin
      t++;
      drive(t);
      tick();
    end
    check("trig_no_early_beats", beat_data.size(), 0);
    check("trig_still_busy", sts_busy, 1);
    t++;
    drive(t);
    ext_trig = 1;
    tick();
    check("trig_entry_not_accepted", m_axis_tvalid, 0);
    for (int i = 0; i < 20 && !sts_done; i++) begin
      t++;
      drive(t);
      tick();
    end
    ext_trig = 0;
    check("trig_done", sts_done, 1);
    check("trig_beats", beat_data.size(), 2);
    if (beat_data.size() == 2) begin
      check("trig_beat0", beat_data[0], exp_word(0, 112));
      check("trig_beat1", beat_data[1], exp_word(1, 113));
      check("trig_last0", beat_last[0], 0);
      check("trig_last1", beat_last[1], 1);
    end

    // Stall: tready low for three cycles drops samples 4..6 and holds sample 3.
    beat_data.delete(); beat_last.delete();
    exp_k = '{1, 2, 3, 7, 8, 9, 10, 11};
    cfg_trig_mode = 0; cfg_num_samples = 8; adc_valid = 1; m_axis_tready = 1;
    drive(0);
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    for (int i = 1; i <= 40 && !sts_done; i++) begin
      drive(i);
      m_axis_tready = (i < 4 || i > 6);
      tick();
      if (i >= 4 && i <= 6) begin
        check($sformatf("stall_hold_valid_%0d", i), m_axis_tvalid, 1);
        check($sformatf("stall_hold_data_%0d", i), m_axis_tdata, exp_word(2, 3));
      end
    end
    m_axis_tready = 1;
    check("stall_done", sts_done, 1);
    check("stall_ovf", sts_overflow, 1);
    check("stall_count", sts_count, 8);
    check("stall_beats", beat_data.size(), 8);
    if (beat_data.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        check($sformatf("stall_beat%0d", j), beat_data[j], exp_word(j, exp_k[j]));
        check($sformatf("stall_last%0d", j), beat_last[j], (j == 7));
      end
    end

    // Abort after three handshakes of a capture of 10.
    beat_data.delete(); beat_last.delete();
    cfg_num_samples = 10; adc_valid = 1; m_axis_tready = 1;
    drive(50);
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    for (int i = 0; i < 30 && beat_data.size() < 3; i++) begin
      tick();
      #3;
    end
    check("abort_reached_3", beat_data.size(), 3);
    @(negedge ACLK);
    cfg_abort = 1;
    m_axis_tready = 0;
    tick();
    cfg_abort = 0;
    check("abort_tvalid", m_axis_tvalid, 0);
    check("abort_tlast", m_axis_tlast, 0);
    check("abort_busy", sts_busy, 0);
    check("abort_done", sts_done, 0);
    check("abort_count", sts_count, 3);
    m_axis_tready = 1;
    tick();
    check("abort_idle_ignores_valid", m_axis_tvalid, 0);
    check("abort_idle_no_ovf", sts_overflow, 0);

    // Asynchronous reset during CAPTURE, then an arm with num=0 stays idle.
    cfg_num_samples = 5; adc_valid = 1; m_axis_tready = 1;
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    tick();
    tick();
    check("prerst_tvalid", m_axis_tvalid, 1);
    #1 ARESET = 1'b1;
    #1;
    check("arst_tvalid", m_axis_tvalid, 0);
    check("arst_tdata", m_axis_tdata, 0);
    check("arst_busy", sts_busy, 0);
    check("arst_count", sts_count, 0);
    check("arst_done", sts_done, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    cfg_num_samples = 0;
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    tick();
    check("num0_busy", sts_busy, 0);
    check("num0_tvalid", m_axis_tvalid, 0);
    adc_valid = 0;

`ifdef AD9648_CAP_TESTPAT_EN
    // Ramp source: capture of 3 yields b = ~ramp, a = ramp.
    beat_data.delete(); beat_last.delete();
    cfg_num_samples = 3; adc_valid = 1; m_axis_tready = 1;
    cfg_arm = 1;
    tick();
    cfg_arm = 0;
    for (int i = 0; i < 20 && !sts_done; i++) tick();
    check("tp_beats", beat_data.size(), 3);
    if (beat_data.size() == 3) begin
      check("tp_beat0", beat_data[0], 32'h3FFF_0000);
      check("tp_beat1", beat_data[1], 32'h3FFE_0001);
      check("tp_beat2", beat_data[2], 32'h3FFD_0002);
    end
    adc_valid = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
